ext_pipe_unit: RTL

Parametrised, pipelined immediate/operand extender for the pipelined datapath, sitting on the ID→EX boundary. It widens the extension-mode set to cover zero, sign, high-position, branch offset, jump target and byte extension. Each result is registered behind a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered in_ready, and a flush input squashes in-flight entries on branch or exception.

---
 rtl/ext_pipe_unit_pkg.sv | 14 +
 rtl/ext_pipe_unit_core.sv | 37 +++
 rtl/ext_pipe_unit.sv | 67 ++++++
 3 files changed

// File: rtl/ext_pipe_unit_pkg.sv
// ext_pipe_unit_pkg: extension mode codes shared by the extender datapath
package ext_pipe_unit_pkg;
  localparam int EXT_OP_W = 3;
  typedef enum logic [EXT_OP_W-1:0] {
    EXT_ZERO    = 3'd0,
    EXT_SIGNED  = 3'd1,
    EXT_HIGHPOS = 3'd2,
    EXT_BRANCH  = 3'd3,
    EXT_JUMP    = 3'd4,
    EXT_BYTE_S  = 3'd5,
    EXT_BYTE_Z  = 3'd6,
    EXT_ILLEGAL = 3'd7
  } ext_op_e;
endpackage

// File: rtl/ext_pipe_unit_core.sv
// ext_core: combinational immediate/operand extension for every mode
module ext_core import ext_pipe_unit_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int HALF_W = 16,
  parameter int IMM_W  = 26
) (
  input  logic [IMM_W-1:0]    in_imm,
  input  logic [EXT_OP_W-1:0] in_op,
  input  logic [DATA_W-1:0]   in_pc,
  output logic [DATA_W-1:0]   result,
  output logic                err
);
  localparam logic [DATA_W-1:0] JMASK = {DATA_W{1'b1}} >> (DATA_W - IMM_W - 2);
  logic [HALF_W-1:0] h;
  logic [7:0]        b;
  logic [DATA_W-1:0] zx, sx, hi, br, jp, bs, bz;
  assign h  = in_imm[HALF_W-1:0];
  assign b  = in_imm[7:0];
  assign zx = DATA_W'(h);
  assign sx = {{(DATA_W-HALF_W){h[HALF_W-1]}}, h};
  assign hi = sx << HALF_W;
  assign br = sx << 2;
  assign jp = (in_pc & ~JMASK) | (DATA_W'(in_imm) << 2);
  assign bs = {{(DATA_W-8){b[7]}}, b};
  assign bz = DATA_W'(b);
  // select the extended value for the requested mode; illegal codes yield zero
  always_comb begin
    err    = in_op == EXT_ILLEGAL;
    result = in_op == EXT_ZERO    ? zx :
             in_op == EXT_SIGNED  ? sx :
             in_op == EXT_HIGHPOS ? hi :
             in_op == EXT_BRANCH  ? br :
             in_op == EXT_JUMP    ? jp :
             in_op == EXT_BYTE_S  ? bs :
             in_op == EXT_BYTE_Z  ? bz : '0;
  end
endmodule

// File: rtl/ext_pipe_unit.sv
// ext_pipe_unit: registered extender behind a valid/ready handshake with a 2-entry skid buffer
module ext_pipe_unit import ext_pipe_unit_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int HALF_W = 16,
  parameter int IMM_W  = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic [EXT_OP_W-1:0] in_op,
  input  logic [DATA_W-1:0]   in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_imm,
  output logic                out_err
);
  logic [DATA_W-1:0] ext_res;
  logic              ext_err;
  logic              main_v, skid_v, main_vn, skid_vn, acc, drain;
  logic [DATA_W:0]   main_d, skid_d, main_dn, skid_dn, ext_d;
  ext_core #(.DATA_W(DATA_W), .HALF_W(HALF_W), .IMM_W(IMM_W)) u_core (
    .in_imm (in_imm),
    .in_op  (in_op),
    .in_pc  (in_pc),
    .result (ext_res),
    .err    (ext_err)
  );
  assign ext_d     = {ext_err, ext_res};
  assign acc       = in_valid && in_ready;
  assign drain     = main_v && out_ready;
  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign {out_err, out_imm} = main_d;
  // refill main from skid first, then from input; overflow into skid when main stalls
  always_comb begin
    main_vn = main_v;
    main_dn = main_d;
    skid_vn = skid_v;
    skid_dn = skid_d;
    if (!main_v || drain) begin
      main_vn = skid_v || acc;
      main_dn = skid_v ? skid_d : acc ? ext_d : '0;
      skid_vn = 1'b0;
      skid_dn = '0;
    end else if (acc) begin
      skid_vn = 1'b1;
      skid_dn = ext_d;
    end
  end
  // state registers; reset and flush empty the buffer and zero the data
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else begin
      main_v <= main_vn;
      skid_v <= skid_vn;
      main_d <= main_dn;
      skid_d <= skid_dn;
    end
  end
endmodule
